// File: rtl/hd44780_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hd44780_pkg
//  Description : Shared types and timing constants for the HD44780 4-bit
//                write path (state encoding, pulse timing, delays).
//  Revision    : 1.0 - initial release
// ============================================================================
package hd44780_pkg;

    // Writer FSM encoding; explicit 3-bit width so the register width is fixed
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_E_HIGH = 3'd2,
        ST_E_LOW  = 3'd3,
        ST_DELAY  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam int c_sysfreq = 48_000_000;
    localparam int c_tsu_cyc = 3;     // >= 40 ns RS/data setup at 48 MHz
    localparam int c_teh_cyc = 12;    // >= 230 ns E high at 48 MHz
    localparam int c_tel_cyc = 14;    // E low, keeps the E period above 500 ns
    localparam int c_us_div  = c_sysfreq / 1_000_000;

    // Standard post-write waits in microseconds
    localparam logic [15:0] c_dly_cmd_us   = 16'd53;
    localparam logic [15:0] c_dly_clear_us = 16'd1640;
    localparam logic [15:0] c_dly_init_us  = 16'd4100;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hd44780_us_tick.sv
`default_nettype none
// ============================================================================
//  Module      : hd44780_us_tick
//  Description : Free-running prescaler with synchronous clear; emits a
//                one-cycle tick every DIV clock cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module hd44780_us_tick
    import hd44780_pkg::*;
#(
    parameter int DIV = c_us_div
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    output logic o_tick
);

    localparam int c_w = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_w-1:0] c_last = c_w'(DIV - 1);

    logic [c_w-1:0] r_cnt;

    // Count 0..DIV-1 and wrap; clear holds the count at zero
    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == c_last) && !i_clr;

endmodule
`default_nettype wire

// File: rtl/hd44780_nibble_writer.sv
`default_nettype none
// ============================================================================
//  Module      : hd44780_nibble_writer
//  Description : Drives one HD44780 write (one or two nibbles) with setup,
//                E-high and E-low timing, then an optional microsecond wait.
//  Revision    : 1.0 - initial release
// ============================================================================
module hd44780_nibble_writer
    import hd44780_pkg::*;
#(
    parameter int SYSFREQ = c_sysfreq,
    parameter int TSU_CYC = c_tsu_cyc,
    parameter int TEH_CYC = c_teh_cyc,
    parameter int TEL_CYC = c_tel_cyc
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        STB_I,
    input  logic [7:0]  DAT_I,
    input  logic        RS_I,
    input  logic        NIB_I,
    input  logic [15:0] DLY_I,
    output logic        BUSY_O,
    output logic        ACK_O,
    output logic        lcd_rs,
    output logic        lcd_e,
    output logic [3:0]  lcd_data
);

    localparam int c_tick_div = SYSFREQ / 1_000_000;
    localparam int c_tmax     = max3(TSU_CYC, TEH_CYC, TEL_CYC);
    localparam int c_cnt_w    = (c_tmax > 1) ? $clog2(c_tmax) : 1;
    localparam logic [c_cnt_w-1:0] c_tsu_last = c_cnt_w'(TSU_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_teh_last = c_cnt_w'(TEH_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_tel_last = c_cnt_w'(TEL_CYC - 1);

    state_t             r_state, w_next_state;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_next;
    logic               r_second, w_second_next;
    logic               r_nib;
    logic [3:0]         r_lo_nib;
    logic [15:0]        r_dly;
    logic [15:0]        r_us, w_us_next;
    logic               w_load, w_lo_load;
    logic               w_tick, w_tick_clr;
    logic               r_busy, r_ack, r_lcd_e, r_lcd_rs;
    logic [3:0]         r_lcd_data;

    // Prescaler only runs while waiting, so every wait starts on a fresh microsecond
    assign w_tick_clr = (r_state != ST_DELAY);

    hd44780_us_tick #(
        .DIV (c_tick_div)
    ) u_us_tick (
        .clk    (CLK_I),
        .rst_n  (RST_I),
        .i_clr  (w_tick_clr),
        .o_tick (w_tick)
    );

    // Next-state, phase counter and microsecond counter
    always_comb begin
        w_next_state  = r_state;
        w_cnt_next    = r_cnt;
        w_second_next = r_second;
        w_us_next     = r_us;
        w_load        = 1'b0;
        w_lo_load     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (STB_I) begin
                    w_load        = 1'b1;
                    w_next_state  = ST_SETUP;
                    w_cnt_next    = '0;
                    w_second_next = 1'b0;
                end
            end
            ST_SETUP: begin
                if (r_cnt == c_tsu_last) begin
                    w_next_state = ST_E_HIGH;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_E_HIGH: begin
                if (r_cnt == c_teh_last) begin
                    w_next_state = ST_E_LOW;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_E_LOW: begin
                if (r_cnt == c_tel_last) begin
                    w_cnt_next = '0;
                    if (!r_second && !r_nib) begin
                        w_second_next = 1'b1;
                        w_lo_load     = 1'b1;
                        w_next_state  = ST_SETUP;
                    end else if (r_dly != 16'd0) begin
                        w_us_next    = '0;
                        w_next_state = ST_DELAY;
                    end else begin
                        w_next_state = ST_DONE;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_DELAY: begin
                if (w_tick) begin
                    // Compare against DLY-1 so 16'hFFFF never needs a 17th bit
                    if (r_us == r_dly - 16'd1) begin
                        w_us_next    = '0;
                        w_next_state = ST_DONE;
                    end else begin
                        w_us_next = r_us + 16'd1;
                    end
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State, latched request and registered pin/handshake outputs
    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_second   <= 1'b0;
            r_nib      <= 1'b0;
            r_lo_nib   <= 4'h0;
            r_dly      <= 16'd0;
            r_us       <= 16'd0;
            r_busy     <= 1'b0;
            r_ack      <= 1'b0;
            r_lcd_e    <= 1'b0;
            r_lcd_rs   <= 1'b0;
            r_lcd_data <= 4'h0;
        end else begin
            r_state  <= w_next_state;
            r_cnt    <= w_cnt_next;
            r_second <= w_second_next;
            r_us     <= w_us_next;
            r_busy   <= (w_next_state != ST_IDLE);
            r_ack    <= (w_next_state == ST_DONE);
            r_lcd_e  <= (w_next_state == ST_E_HIGH);
            if (w_load) begin
                r_nib      <= NIB_I;
                r_lo_nib   <= DAT_I[3:0];
                r_dly      <= DLY_I;
                r_lcd_rs   <= RS_I;
                r_lcd_data <= DAT_I[7:4];
            end
            if (w_lo_load) begin
                r_lcd_data <= r_lo_nib;
            end
        end
    end

    assign BUSY_O   = r_busy;
    assign ACK_O    = r_ack;
    assign lcd_e    = r_lcd_e;
    assign lcd_rs   = r_lcd_rs;
    assign lcd_data = r_lcd_data;

endmodule
`default_nettype wire

// File: tb/tb_hd44780_nibble_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hd44780_nibble_writer
//  Description : Directed, scoreboarded bench for hd44780_nibble_writer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hd44780_nibble_writer;

    localparam int c_tsu = 3;
    localparam int c_teh = 12;
    localparam int c_tel = 14;
    localparam int c_us  = 48;
    localparam int c_nib = c_tsu + c_teh + c_tel;

    logic        clk = 1'b0;
    logic        RST_I, STB_I, RS_I, NIB_I;
    logic [7:0]  DAT_I;
    logic [15:0] DLY_I;
    logic        BUSY_O, ACK_O, lcd_rs, lcd_e;
    logic [3:0]  lcd_data;

    int checks = 0;
    int errors = 0;
    int edge_no = 0;
    int s_edge = 0;
    logic [4:0] q[$];

    hd44780_nibble_writer dut (
        .CLK_I    (clk),
        .RST_I    (RST_I),
        .STB_I    (STB_I),
        .DAT_I    (DAT_I),
        .RS_I     (RS_I),
        .NIB_I    (NIB_I),
        .DLY_I    (DLY_I),
        .BUSY_O   (BUSY_O),
        .ACK_O    (ACK_O),
        .lcd_rs   (lcd_rs),
        .lcd_e    (lcd_e),
        .lcd_data (lcd_data)
    );

    always #10 clk = ~clk;

    always @(posedge clk) edge_no <= edge_no + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pin monitor: scoreboard pop on each E rise plus timing checks
    int   cyc = 0, fall_cyc = 0, rise_cyc = 0, stable = 0;
    bit   have_fall = 0, have_rise = 0, rst_prev = 0;
    logic prev_e = 1'b0;
    logic [4:0] prev_pins = 5'h0;
    logic [4:0] exp_pins;
    always @(negedge clk) begin
        cyc++;
        if (!RST_I || !rst_prev) begin
            have_fall = 0;
            have_rise = 0;
            stable    = 0;
        end else begin
            if ({lcd_rs, lcd_data} !== prev_pins) begin
                chk("pins_hold", {30'd0, lcd_e, (have_fall && (cyc - fall_cyc) < c_tel)}, 32'd0);
                stable = 0;
            end else begin
                stable++;
            end
            if (lcd_e && !prev_e) begin
                chk("setup_before_e", (stable >= c_tsu), 1);
                if (have_rise) chk("e_period", ((cyc - rise_cyc) >= c_teh + c_tel), 1);
                rise_cyc  = cyc;
                have_rise = 1;
                chk("sb_nonempty", (q.size() > 0), 1);
                if (q.size() > 0) begin
                    exp_pins = q.pop_front();
                    chk("nibble", {lcd_rs, lcd_data}, exp_pins);
                end
                chk("e_busy", BUSY_O, 1);
            end
            if (!lcd_e && prev_e) begin
                chk("e_high_len", cyc - rise_cyc, c_teh);
                fall_cyc  = cyc;
                have_fall = 1;
            end
        end
        prev_e    = lcd_e;
        prev_pins = {lcd_rs, lcd_data};
        rst_prev  = RST_I;
    end

    // Issue a request; the strobe is dropped after the latching edge unless held
    task automatic xfer(input logic [7:0] d, input logic rs, input logic nib,
                        input logic [15:0] dly, input bit hold);
        @(posedge clk);
        #1;
        STB_I = 1'b1; DAT_I = d; RS_I = rs; NIB_I = nib; DLY_I = dly;
        s_edge = edge_no + 1;
        q.push_back({rs, d[7:4]});
        if (!nib) q.push_back({rs, d[3:0]});
        @(posedge clk);
        #1;
        if (!hold) begin
            STB_I = 1'b0; DAT_I = ~d; RS_I = ~rs; NIB_I = ~nib; DLY_I = dly + 16'd7;
        end
    endtask

    // Wait for ACK; latency counts the latching edge as 1 through the end of the ACK cycle
    task automatic wait_ack(input int exp_lat, input string tag);
        bit got;
        got = 0;
        for (int i = 0; i < exp_lat + 100; i++) begin
            @(negedge clk);
            if (ACK_O === 1'b1) begin
                got = 1;
                break;
            end
        end
        chk({tag, "_ack_seen"}, got, 1);
        if (got) begin
            chk({tag, "_latency"}, edge_no - s_edge + 2, exp_lat);
            chk({tag, "_busy_in_done"}, BUSY_O, 1);
            @(negedge clk);
            chk({tag, "_idle_after"}, {ACK_O, BUSY_O}, 2'b00);
        end
    endtask

    int n_ack;

    initial begin
        // Reset with a strobe present: reset must win
        RST_I = 1'b0; STB_I = 1'b1; DAT_I = 8'hFF; RS_I = 1'b1; NIB_I = 1'b0; DLY_I = 16'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {lcd_e, lcd_rs, lcd_data, BUSY_O, ACK_O}, 0);
        @(posedge clk);
        #1;
        RST_I = 1'b1; STB_I = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", {BUSY_O, lcd_e}, 0);

        // Two-nibble data write, no wait
        xfer(8'hA5, 1'b1, 1'b0, 16'd0, 0);
        wait_ack(1 + 2 * c_nib + 1, "a5");
        chk("retain_pins", {lcd_rs, lcd_data}, 5'h15);

        // Single-nibble init write with a wait
        xfer(8'h30, 1'b0, 1'b1, 16'd100, 0);
        wait_ack(1 + c_nib + 100 * c_us + 1, "nib30");

        // Shortest non-zero wait
        xfer(8'h0F, 1'b0, 1'b0, 16'd1, 0);
        wait_ack(1 + 2 * c_nib + c_us + 1, "dly1");

        // Strobes during busy are ignored
        xfer(8'hC3, 1'b1, 1'b0, 16'd0, 0);
        repeat (3) @(posedge clk);
        #1; STB_I = 1'b1; DAT_I = 8'h81; RS_I = 1'b0;
        @(posedge clk);
        #1; STB_I = 1'b0;
        repeat (24) @(posedge clk);
        #1; STB_I = 1'b1; DAT_I = 8'h7E; RS_I = 1'b0;
        @(posedge clk);
        #1; STB_I = 1'b0;
        wait_ack(1 + 2 * c_nib + 1, "glitch");
        n_ack = 0;
        repeat (70) begin
            @(negedge clk);
            if (ACK_O === 1'b1 || BUSY_O === 1'b1) n_ack++;
        end
        chk("no_queued_xfer", n_ack, 0);

        // Reset while E is high aborts the transfer
        xfer(8'hA5, 1'b1, 1'b0, 16'd0, 0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("e_high_before_rst", lcd_e, 1);
        @(posedge clk);
        #1; RST_I = 1'b0;
        @(posedge clk);
        #1; RST_I = 1'b1;
        q.delete();
        @(negedge clk);
        chk("abort_outputs", {lcd_e, lcd_rs, lcd_data, BUSY_O, ACK_O}, 0);
        n_ack = 0;
        repeat (80) begin
            @(negedge clk);
            if (ACK_O === 1'b1) n_ack++;
        end
        chk("no_ack_after_abort", n_ack, 0);
        xfer(8'hA5, 1'b1, 1'b0, 16'd0, 0);
        wait_ack(1 + 2 * c_nib + 1, "post_abort");

        // Strobe held high: back-to-back transfers with the command wait
        xfer(8'h5A, 1'b1, 1'b0, 16'd53, 1);
        q.push_back({1'b1, 4'h5});
        q.push_back({1'b1, 4'hA});
        wait_ack(1 + 2 * c_nib + 53 * c_us + 1, "b2b_first");
        @(posedge clk);
        #1;
        s_edge = edge_no;
        STB_I = 1'b0; DAT_I = 8'h00; RS_I = 1'b0; DLY_I = 16'd0;
        @(negedge clk);
        chk("b2b_relatch", BUSY_O, 1);
        wait_ack(1 + 2 * c_nib + 53 * c_us + 1, "b2b_second");

        repeat (5) @(negedge clk);
        chk("sb_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
